// File: rtl/result_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_capture_pkg
// Description : Shared types for the result capture block. Holds the 56-bit
//               capture entry layout and the write-side FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package result_capture_pkg;

  // One captured measurement. The field order sets the packed bit layout:
  // freq is bits [55:32], phase_a is [31:16] and phase_b is [15:0].
  typedef struct packed {
    logic [23:0] freq;     // UQ24.0
    logic [15:0] phase_a;  // Q3.13
    logic [15:0] phase_b;  // Q3.13
  } entry_t;

  localparam int c_ENTRY_W = $bits(entry_t);

  // Write-side frame FSM
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

endpackage : result_capture_pkg
`default_nettype wire

// File: rtl/result_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : result_bank_ram
// Description : Simple dual-port RAM, 2*DEPTH x 56 bits, one write port and
//               one read port with a registered read. The upper address bit
//               selects the ping-pong bank. Contents are never reset.
// Ports       : clk        - clock
//               wr_en_i    - write enable
//               wr_addr_i  - {bank, index} write address
//               wr_data_i  - entry to write
//               rd_addr_i  - {bank, index} read address
//               rd_data_o  - entry read, one cycle after rd_addr_i
// Revision    : 1.0 - initial release
// ============================================================================
module result_bank_ram
  import result_capture_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [AWIDTH:0]   wr_addr_i,
  input  entry_t            wr_data_i,
  input  logic [AWIDTH:0]   rd_addr_i,
  output entry_t            rd_data_o
);

  entry_t mem_q [2*DEPTH];
  entry_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule : result_bank_ram
`default_nettype wire

// File: rtl/result_capture.sv
`default_nettype none
// ============================================================================
// Module      : result_capture
// Description : Captures framed {freq, phaseA, phaseB} entries into two
//               ping-pong banks and presents completed frames to a host,
//               oldest first. Frames arriving with no free bank, or longer
//               than DEPTH, are dropped and counted.
// Ports       : clk, reset              - clock, synchronous active-high reset
//               sink_valid/sop/eop      - input entry strobe and framing
//               sink_freq/phaseA/phaseB - entry payload
//               frame_ready, frame_len  - oldest held frame status / length
//               frame_ack               - host releases oldest held frame
//               rd_addr, rd_data        - random read of oldest frame (1 cycle)
//               drop_cnt                - saturating dropped-frame count
//               err_sop, err_len        - sticky framing error flags
// Revision    : 1.0 - initial release
// ============================================================================
module result_capture
  import result_capture_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sink_valid,
  input  logic              sink_sop,
  input  logic              sink_eop,
  input  logic [23:0]       sink_freq,
  input  logic [15:0]       sink_phaseA,
  input  logic [15:0]       sink_phaseB,
  output logic              frame_ready,
  output logic [AWIDTH:0]   frame_len,
  input  logic              frame_ack,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [55:0]       rd_data,
  output logic [15:0]       drop_cnt,
  output logic              err_sop,
  output logic              err_len
);

  localparam logic [AWIDTH:0] c_IDX_OVF = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] c_IDX_ONE = (AWIDTH+1)'(1);

  wr_state_e         state_q, state_d;
  logic [AWIDTH:0]   idx_q, idx_d;
  logic              wr_bank_q;
  logic              rd_ptr_q;
  logic [1:0]        full_q;
  logic [AWIDTH:0]   len_q [2];
  logic [15:0]       drop_q;
  logic              err_sop_q;
  logic              err_len_q;
  logic              rd_mask_q;

  logic              w_wr_en;
  logic [AWIDTH:0]   w_wr_idx;
  logic              w_complete;
  logic              w_drop_inc;
  logic              w_set_err_sop;
  logic              w_set_err_len;
  logic              w_ack;
  logic              w_bank_free;
  entry_t            w_wr_data;
  entry_t            w_ram_rd;

  assign w_bank_free = ~full_q[wr_bank_q];
  assign w_ack       = frame_ack & full_q[rd_ptr_q];
  assign w_wr_data   = '{freq: sink_freq, phase_a: sink_phaseA, phase_b: sink_phaseB};

  // Next-state logic. Cycles without sink_valid leave everything untouched.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    w_wr_en       = 1'b0;
    w_wr_idx      = '0;
    w_complete    = 1'b0;
    w_drop_inc    = 1'b0;
    w_set_err_sop = 1'b0;
    w_set_err_len = 1'b0;
    if (sink_valid) begin
      unique case (state_q)
        ST_IDLE, ST_DISCARD: begin
          if (sink_sop) begin
            if (w_bank_free) begin
              w_wr_en = 1'b1;
              if (sink_eop) begin
                w_complete = 1'b1;
                state_d    = ST_IDLE;
              end else begin
                idx_d   = c_IDX_ONE;
                state_d = ST_CAPTURE;
              end
            end else begin
              w_drop_inc = 1'b1;
              state_d    = sink_eop ? ST_IDLE : ST_DISCARD;
            end
          end else if (state_q == ST_DISCARD && sink_eop) begin
            state_d = ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (sink_sop) begin
            // Restart in the same bank; the partial frame is simply overwritten.
            w_set_err_sop = 1'b1;
            w_wr_en       = 1'b1;
            if (sink_eop) begin
              w_complete = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              idx_d = c_IDX_ONE;
            end
          end else if (idx_q == c_IDX_OVF) begin
            w_set_err_len = 1'b1;
            w_drop_inc    = 1'b1;
            state_d       = sink_eop ? ST_IDLE : ST_DISCARD;
          end else begin
            w_wr_en  = 1'b1;
            w_wr_idx = idx_q;
            if (sink_eop) begin
              w_complete = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              idx_d = idx_q + c_IDX_ONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_ptr_q  <= 1'b0;
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      drop_q    <= '0;
      err_sop_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Completion and ack always target different banks: the write bank is
      // never full while being filled, and ack only acts on a full bank.
      if (w_complete) begin
        full_q[wr_bank_q] <= 1'b1;
        len_q[wr_bank_q]  <= w_wr_idx + c_IDX_ONE;
        wr_bank_q         <= ~wr_bank_q;
      end
      if (w_ack) begin
        full_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= ~rd_ptr_q;
      end
      if (w_drop_inc && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
      if (w_set_err_sop) err_sop_q <= 1'b1;
      if (w_set_err_len) err_len_q <= 1'b1;
    end
  end

  // The RAM read register is not reset, so the output is forced to zero for
  // the cycle that follows a reset edge.
  always_ff @(posedge clk) begin
    rd_mask_q <= reset;
  end

  result_bank_ram #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (w_wr_en & ~reset),
    .wr_addr_i ({wr_bank_q, w_wr_idx[AWIDTH-1:0]}),
    .wr_data_i (w_wr_data),
    .rd_addr_i ({rd_ptr_q, rd_addr}),
    .rd_data_o (w_ram_rd)
  );

  assign frame_ready = full_q[rd_ptr_q];
  assign frame_len   = full_q[rd_ptr_q] ? len_q[rd_ptr_q] : '0;
  assign rd_data     = rd_mask_q ? 56'd0 : w_ram_rd;
  assign drop_cnt    = drop_q;
  assign err_sop     = err_sop_q;
  assign err_len     = err_len_q;

endmodule : result_capture
`default_nettype wire

// File: tb/tb_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_capture
// Description : Self-checking bench for result_capture (DEPTH=16). Frames
//               expected to be held are pushed to a scoreboard as they are
//               driven and popped when the host side reads them back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_capture;

  localparam int DEPTH  = 16;
  localparam int AWIDTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              sink_valid, sink_sop, sink_eop;
  logic [23:0]       sink_freq;
  logic [15:0]       sink_phaseA, sink_phaseB;
  logic              frame_ready;
  logic [AWIDTH:0]   frame_len;
  logic              frame_ack;
  logic [AWIDTH-1:0] rd_addr;
  logic [55:0]       rd_data;
  logic [15:0]       drop_cnt;
  logic              err_sop, err_len;

  int n_checks = 0;
  int n_fails  = 0;

  logic [55:0] exp_data [$];
  int          exp_len  [$];

  always #5 clk = ~clk;

  result_capture #(
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sink_valid  (sink_valid),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_freq   (sink_freq),
    .sink_phaseA (sink_phaseA),
    .sink_phaseB (sink_phaseB),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .drop_cnt    (drop_cnt),
    .err_sop     (err_sop),
    .err_len     (err_len)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] mk(input int base, input int i);
    logic [23:0] f;
    logic [15:0] a, b;
    f = 24'(base + i);
    a = 16'(16'h1000 + base * 7 + i);
    b = 16'(16'hF000 - base - 3 * i);
    return {f, a, b};
  endfunction

  // Drive one entry for exactly one clock; all driving is done at negedge.
  task automatic send(input bit sop, input bit eop, input logic [55:0] d, input bit ack);
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    {sink_freq, sink_phaseA, sink_phaseB} = d;
    frame_ack  = ack;
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    frame_ack  = 1'b0;
  endtask

  task automatic send_frame(input int n, input int base, input bit hold, input bit ack_on_eop);
    logic [55:0] d;
    if (hold) exp_len.push_back(n);
    for (int i = 0; i < n; i++) begin
      d = mk(base, i);
      if (hold) exp_data.push_back(d);
      send(i == 0, i == n - 1, d, ack_on_eop && (i == n - 1));
    end
  endtask

  task automatic send_partial(input int n, input int base);
    for (int i = 0; i < n; i++) send(i == 0, 1'b0, mk(base, i), 1'b0);
  endtask

  // Pop the oldest expected frame and read it back through rd_addr.
  task automatic check_frame(input string tag, input bit ack);
    int          len;
    logic [55:0] d;
    check_val($sformatf("%s sb_nonempty", tag), 64'(exp_len.size() != 0), 64'd1);
    if (exp_len.size() == 0) return;
    len = exp_len.pop_front();
    check_val($sformatf("%s ready", tag), 64'(frame_ready), 64'd1);
    check_val($sformatf("%s len", tag), 64'(frame_len), 64'(len));
    for (int i = 0; i < len; i++) begin
      rd_addr = AWIDTH'(i);
      @(negedge clk);
      d = exp_data.pop_front();
      check_val($sformatf("%s data[%0d]", tag, i), 64'(rd_data), 64'(d));
    end
    if (ack) begin
      frame_ack = 1'b1;
      @(negedge clk);
      frame_ack = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val($sformatf("%s ready", tag), 64'(frame_ready), 64'd0);
    check_val($sformatf("%s len", tag), 64'(frame_len), 64'd0);
    check_val($sformatf("%s rd_data", tag), 64'(rd_data), 64'd0);
    check_val($sformatf("%s drop", tag), 64'(drop_cnt), 64'd0);
    check_val($sformatf("%s err_sop", tag), 64'(err_sop), 64'd0);
    check_val($sformatf("%s err_len", tag), 64'(err_len), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    sink_valid  = 1'b0;
    sink_sop    = 1'b0;
    sink_eop    = 1'b0;
    sink_freq   = '0;
    sink_phaseA = '0;
    sink_phaseB = '0;
    frame_ack   = 1'b0;
    rd_addr     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("rst");

    // Single 4-entry frame, freq 1..4, then release it
    send_frame(4, 1, 1'b1, 1'b0);
    check_frame("f4", 1'b1);
    check_val("f4 ready_after_ack", 64'(frame_ready), 64'd0);

    // Three 8-entry frames with no ack: the third finds both banks full
    send_frame(8, 16, 1'b1, 1'b0);
    send_frame(8, 32, 1'b1, 1'b0);
    send_frame(8, 48, 1'b0, 1'b0);
    check_val("f8x3 drop", 64'(drop_cnt), 64'd1);
    check_frame("f8x3 first", 1'b1);
    check_frame("f8x3 second", 1'b1);
    check_val("f8x3 ready_after", 64'(frame_ready), 64'd0);

    // sop arriving mid-frame restarts the frame
    send_partial(5, 64);
    send_frame(3, 80, 1'b1, 1'b0);
    check_val("midsop err_sop", 64'(err_sop), 64'd1);
    check_val("midsop err_len", 64'(err_len), 64'd0);
    check_frame("midsop", 1'b1);

    // 20-entry frame overflows DEPTH=16
    send_frame(20, 96, 1'b0, 1'b0);
    check_val("ovf err_len", 64'(err_len), 64'd1);
    check_val("ovf drop", 64'(drop_cnt), 64'd2);
    send_frame(2, 128, 1'b1, 1'b0);
    check_frame("ovf next", 1'b1);
    check_val("ovf ready_after", 64'(frame_ready), 64'd0);

    // Single-entry frame, then ack coincident with the next frame's eop
    send_frame(1, 140, 1'b1, 1'b0);
    check_frame("single", 1'b0);
    send_frame(3, 150, 1'b1, 1'b1);
    @(negedge clk);
    send_frame(2, 160, 1'b1, 1'b0);
    check_val("ackeop drop", 64'(drop_cnt), 64'd2);
    check_frame("ackeop y", 1'b1);
    check_frame("ackeop z", 1'b1);
    check_val("ackeop ready_after", 64'(frame_ready), 64'd0);

    // Reset at entry 3 of a frame with one frame held
    send_frame(2, 170, 1'b1, 1'b0);
    send_partial(3, 180);
    sink_valid = 1'b1;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    {sink_freq, sink_phaseA, sink_phaseB} = mk(180, 3);
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    sink_valid = 1'b0;
    exp_len.delete();
    exp_data.delete();
    check_reset_values("midrst");
    send_frame(4, 200, 1'b1, 1'b0);
    check_frame("postrst", 1'b1);
    check_val("postrst ready_after", 64'(frame_ready), 64'd0);
    check_val("sb drained", 64'(exp_data.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_result_capture
`default_nettype wire

// File: doc/result_capture.md
RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 Parameter DEPTH, default 2048, maximum entries per frame per bank.
REQ-002 Parameter AWIDTH, default $clog2(DEPTH), entry address width.
REQ-003 clk  in  1  main clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sink_valid  in  1  input entry valid.
REQ-006 sink_sop  in  1  first entry of frame; qualified by sink_valid.
REQ-007 sink_eop  in  1  last entry of frame; qualified by sink_valid.
REQ-008 sink_freq  in  24  frequency, UQ24.0.
REQ-009 sink_phaseA  in  16  phase A, Q3.13.
REQ-010 sink_phaseB  in  16  phase B, Q3.13.
REQ-011 frame_ready  out  1  at least one complete frame held.
REQ-012 frame_len  out  AWIDTH+1  entry count of oldest held frame, 1..DEPTH.
REQ-013 frame_ack  in  1  host releases oldest held frame; ignored when frame_ready=0.
REQ-014 rd_addr  in  AWIDTH  entry index within oldest held frame.
REQ-015 rd_data  out  56  {freq, phaseA, phaseB} at rd_addr.
REQ-016 drop_cnt  out  16  frames discarded, saturating.
REQ-017 err_sop  out  1  sticky: sop received mid-frame.
REQ-018 err_len  out  1  sticky: frame longer than DEPTH.

Function
REQ-019 Two storage banks (ping-pong); each bank holds one frame plus its length and a full flag.
REQ-020 Write FSM states IDLE, CAPTURE, DISCARD.
REQ-021 IDLE: valid&sop with a free bank -> write entry 0, go CAPTURE (or stay IDLE and mark bank full if eop in the same cycle; length 1).
REQ-022 IDLE: valid&sop with no free bank -> drop_cnt+1, go DISCARD (stay IDLE if eop in the same cycle).
REQ-023 IDLE: valid without sop -> ignored, no flag.
REQ-024 CAPTURE: valid without sop -> write at next index; on eop mark bank full, store length, go IDLE.
REQ-025 CAPTURE: valid&sop -> set err_sop, abandon the partial frame, restart the frame at index 0 in the same bank.
REQ-026 CAPTURE: valid at index DEPTH (overflow) -> set err_len, abandon the frame, drop_cnt+1, go DISCARD (IDLE if eop).
REQ-027 DISCARD: ignore entries until valid&eop, then go IDLE; valid&sop in DISCARD is handled as in IDLE.
REQ-028 Cycles with sink_valid=0 never advance state or index.
REQ-029 Banks fill in alternating order; read order equals completion order (oldest first).
REQ-030 frame_ready=1 on the cycle after the eop write that completes a frame.
REQ-031 rd_data latency is one cycle, registered from rd_addr against the oldest full bank; rd_addr>=frame_len returns undefined data.
REQ-032 frame_ack clears the oldest bank's full flag in the same edge; next frame (if any) is visible on the following cycle.
REQ-033 frame_ack and eop completion in the same cycle: both take effect; a freed bank is available to the next sop one cycle later.
REQ-034 drop_cnt saturates at 16'hFFFF.
REQ-035 err_sop and err_len clear only on reset.

Reset
REQ-036 reset: FSM=IDLE, both banks empty, write pointer/read pointer=bank 0, frame_ready=0, frame_len=0, rd_data=0, drop_cnt=0, err_sop=0, err_len=0.
REQ-037 reset mid-frame abandons the partial frame, discards held frames, and ignores inputs in that cycle.
REQ-038 Bank RAM contents are not reset.

Structure
REQ-039 Shared package holds the 56-bit entry typedef (freq, phaseA, phaseB fields) and the write-FSM state enum.
REQ-040 One sub-module, result_bank_ram: simple dual-port RAM, 2*DEPTH x 56, registered read, inferable as block RAM.

Verification
REQ-041 Frame of 4 entries (freq 1..4), then ack -> frame_ready=1, frame_len=4, rd_addr=2 gives freq=3 one cycle later; after ack, frame_ready=0.
REQ-042 Three 8-entry frames with no ack -> first two held, third dropped, drop_cnt=1; ack -> frame_len=8 of frame 2.
REQ-043 sop at entry 5 of a frame, then a 3-entry frame -> err_sop=1, frame_len=3.
REQ-044 DEPTH=16, 20-entry frame, then a 2-entry frame -> err_len=1, drop_cnt=1, only the 2-entry frame held.
REQ-045 Single cycle valid&sop&eop -> frame_len=1; frame_ack coincident with the next eop -> no drop.
REQ-046 reset asserted at entry 3 of a frame with one frame held -> all outputs at reset values; the next full frame is captured normally.
